// File: rtl/ram_pkg.sv
// Shared types and width constants for the RAM burst master.
package ram_pkg;

   localparam int unsigned LEN_W  = 4;
   localparam int unsigned TCNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_WAIT,
      ST_WR_ISSUE,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_RD_RESP
   } state_t;

endpackage

// File: rtl/ram_master.sv
// Burst master for a single-port RAM: turns read/write burst commands into
// one-at-a-time RAM accesses, with a per-beat read-return timeout.
module ram_master
   import ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned TIMEOUT    = 7
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_W-1:0]      req_len,
   input  logic                  wdata_valid,
   output logic                  wdata_ready,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_last,
   output logic                  rsp_err,
   output logic                  ram_en,
   output logic                  ram_wr_rd,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   input  logic                  ram_out_en,
   output logic                  busy
);

   state_t            state;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  beat;
   logic [TCNT_W-1:0] tcnt;

   // ram_addr doubles as the running burst address.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         len         <= '0;
         beat        <= '0;
         tcnt        <= '0;
         req_ready   <= 1'b0;
         wdata_ready <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_last    <= 1'b0;
         rsp_err     <= 1'b0;
         ram_en      <= 1'b0;
         ram_wr_rd   <= 1'b0;
         ram_addr    <= '0;
         ram_data_in <= '0;
         busy        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  len       <= req_len;
                  beat      <= '0;
                  ram_addr  <= req_addr;
                  if (req_wr) begin
                     state       <= ST_WR_WAIT;
                     wdata_ready <= 1'b1;
                  end else begin
                     state     <= ST_RD_ISSUE;
                     ram_en    <= 1'b1;
                     ram_wr_rd <= 1'b0;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end

            ST_WR_WAIT: begin
               if (wdata_valid) begin
                  state       <= ST_WR_ISSUE;
                  wdata_ready <= 1'b0;
                  ram_data_in <= wdata;
                  ram_en      <= 1'b1;
                  ram_wr_rd   <= 1'b1;
               end
            end

            ST_WR_ISSUE: begin
               ram_en    <= 1'b0;
               ram_wr_rd <= 1'b0;
               if (beat == len) begin
                  state     <= ST_IDLE;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  state       <= ST_WR_WAIT;
                  wdata_ready <= 1'b1;
                  beat        <= beat + LEN_W'(1);
                  ram_addr    <= ram_addr + ADDR_WIDTH'(1);
               end
            end

            ST_RD_ISSUE: begin
               state  <= ST_RD_WAIT;
               ram_en <= 1'b0;
               tcnt   <= '0;
            end

            // A return beat wins over a timeout landing in the same cycle.
            ST_RD_WAIT: begin
               if (ram_out_en) begin
                  state     <= ST_RD_RESP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= ram_data_out;
                  rsp_err   <= 1'b0;
                  rsp_last  <= (beat == len);
               end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                  state     <= ST_RD_RESP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_last  <= (beat == len);
               end else begin
                  tcnt <= tcnt + TCNT_W'(1);
               end
            end

            ST_RD_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_last  <= 1'b0;
                  if (beat == len) begin
                     state     <= ST_IDLE;
                     req_ready <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     state     <= ST_RD_ISSUE;
                     beat      <= beat + LEN_W'(1);
                     ram_addr  <= ram_addr + ADDR_WIDTH'(1);
                     ram_en    <= 1'b1;
                     ram_wr_rd <= 1'b0;
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master with a behavioural single-port RAM and
// scoreboards for RAM writes and read responses.
module tb_ram_master;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int TO = 7;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          last;
      logic          err;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          req_valid = 1'b0, req_wr = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [3:0]    req_len = '0;
   logic          wdata_valid = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic          rsp_ready = 1'b0;
   logic          req_ready, wdata_ready, rsp_valid, rsp_last, rsp_err;
   logic [DW-1:0] rsp_data, ram_data_in;
   logic          ram_en, ram_wr_rd, busy;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data_out = '0;
   logic          ram_out_en = 1'b0;

   logic          ram_mute = 1'b0;
   logic          spur = 1'b0;
   logic          prev_en = 1'b0;
   int            b2b_viol = 0;
   int            vectors = 0;
   int            miscompares = 0;
   logic [DW-1:0] mem [0:(1<<AW)-1];
   rsp_t          exp_rsp [$];
   logic [AW+DW-1:0] exp_wr [$];

   always #5 clk = ~clk;

   ram_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_len(req_len),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_last(rsp_last), .rsp_err(rsp_err),
      .ram_en(ram_en), .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
      .ram_out_en(ram_out_en), .busy(busy)
   );

   initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

   // RAM model: writes commit at the edge, read data returns one cycle later.
   always @(posedge clk) begin
      if (ram_en && ram_wr_rd) mem[ram_addr] <= ram_data_in;
      if (ram_en && !ram_wr_rd && !ram_mute) begin
         ram_out_en   <= 1'b1;
         ram_data_out <= mem[ram_addr];
      end else begin
         ram_out_en   <= spur;
         ram_data_out <= 8'hEE;
      end
   end

   // Write scoreboard and back-to-back command monitor.
   always @(negedge clk) begin
      prev_en <= ram_en;
      if (ram_en && prev_en) b2b_viol <= b2b_viol + 1;
      if (ram_en && ram_wr_rd) begin
         vectors++;
         if (exp_wr.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write addr=%0d data=%h", ram_addr, ram_data_in);
         end else begin
            logic [AW+DW-1:0] e;
            e = exp_wr.pop_front();
            if ({ram_addr, ram_data_in} !== e) begin
               miscompares++;
               $display("FAIL ram_write got addr=%0d data=%h exp addr=%0d data=%h",
                        ram_addr, ram_data_in, e[AW+DW-1:DW], e[DW-1:0]);
            end
         end
      end
   end

   task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [3:0] l);
      int t = 0;
      @(negedge clk);
      while (!req_ready && t < 50) begin @(negedge clk); t++; end
      if (!req_ready) begin
         vectors++; miscompares++;
         $display("FAIL cmd_timeout req_ready=%b exp 1", req_ready);
      end
      req_valid = 1'b1; req_wr = w; req_addr = a; req_len = l;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic send_wdata(input logic [DW-1:0] d, input logic [AW-1:0] a, input int gap);
      int t = 0;
      repeat (gap) @(negedge clk);
      while (!wdata_ready && t < 50) begin @(negedge clk); t++; end
      if (!wdata_ready) begin
         vectors++; miscompares++;
         $display("FAIL wdata_timeout wdata_ready=%b exp 1", wdata_ready);
      end
      exp_wr.push_back({a, d});
      wdata_valid = 1'b1; wdata = d;
      @(negedge clk);
      wdata_valid = 1'b0;
   endtask

   task automatic recv_rsp(input int stall);
      int t = 0;
      rsp_t e;
      logic [DW-1:0] d0;
      while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
      e = exp_rsp.pop_front();
      vectors++;
      if (!rsp_valid) begin
         miscompares++;
         $display("FAIL rsp_timeout rsp_valid=%b exp 1", rsp_valid);
         return;
      end
      d0 = rsp_data;
      spur = (stall > 0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         vectors++;
         if (rsp_data !== d0 || rsp_valid !== 1'b1 || ram_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rsp_stall data=%h valid=%b ram_en=%b exp data=%h valid=1 ram_en=0",
                     rsp_data, rsp_valid, ram_en, d0);
         end
      end
      spur = 1'b0;
      if ({rsp_data, rsp_last, rsp_err} !== e) begin
         miscompares++;
         $display("FAIL rsp got data=%h last=%b err=%b exp data=%h last=%b err=%b",
                  rsp_data, rsp_last, rsp_err, e.d, e.last, e.err);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 100) begin @(negedge clk); t++; end
      vectors++;
      if (busy !== 1'b0 || exp_wr.size() != 0 || exp_rsp.size() != 0) begin
         miscompares++;
         $display("FAIL idle busy=%b wr_left=%0d rsp_left=%0d exp 0/0/0",
                  busy, exp_wr.size(), exp_rsp.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({req_ready, wdata_ready, rsp_valid, rsp_last, rsp_err, ram_en, ram_wr_rd, busy} !== 8'h00
          || rsp_data !== '0 || ram_addr !== '0 || ram_data_in !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs rr=%b wr=%b rv=%b rl=%b re=%b en=%b wrd=%b busy=%b rd=%h a=%h di=%h exp all 0",
                  req_ready, wdata_ready, rsp_valid, rsp_last, rsp_err, ram_en, ram_wr_rd, busy,
                  rsp_data, ram_addr, ram_data_in);
      end
      rstn = 1'b1;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release req_ready=%b busy=%b exp 1 0", req_ready, busy);
      end
   endtask

   task automatic test_single();
      send_cmd(1'b1, 4'd3, 4'd0);
      send_wdata(8'hA5, 4'd3, 0);
      wait_idle();
      exp_rsp.push_back('{d: 8'hA5, last: 1'b1, err: 1'b0});
      send_cmd(1'b0, 4'd3, 4'd0);
      recv_rsp(0);
      wait_idle();
   endtask

   task automatic test_wrap_burst();
      send_cmd(1'b1, 4'd14, 4'd3);
      for (int i = 0; i < 4; i++) send_wdata(DW'(i + 1), AW'(14 + i), 0);
      wait_idle();
      for (int i = 0; i < 4; i++) exp_rsp.push_back('{d: DW'(i + 1), last: (i == 3), err: 1'b0});
      send_cmd(1'b0, 4'd14, 4'd3);
      for (int i = 0; i < 4; i++) recv_rsp(0);
      wait_idle();
   endtask

   task automatic test_timeout();
      int t = 0;
      int cyc = 0;
      ram_mute = 1'b1;
      exp_rsp.push_back('{d: 8'h00, last: 1'b1, err: 1'b1});
      send_cmd(1'b0, 4'd3, 4'd0);
      while (!ram_en && t < 20) begin @(negedge clk); t++; end
      while (!rsp_valid && cyc < 40) begin @(negedge clk); cyc++; end
      vectors++;
      if (cyc != TO + 1) begin
         miscompares++;
         $display("FAIL timeout_latency got %0d cycles exp %0d", cyc, TO + 1);
      end
      recv_rsp(0);
      ram_mute = 1'b0;
      wait_idle();
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) exp_rsp.push_back('{d: DW'(i + 1), last: (i == 2), err: 1'b0});
      send_cmd(1'b0, 4'd14, 4'd2);
      for (int i = 0; i < 3; i++) recv_rsp(5);
      wait_idle();
   endtask

   task automatic test_reset_mid_burst();
      send_cmd(1'b1, 4'd5, 4'd3);
      send_wdata(8'h11, 4'd5, 0);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || ram_en !== 1'b0 || wdata_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid busy=%b ram_en=%b wdata_ready=%b exp 0 0 0",
                  busy, ram_en, wdata_ready);
      end
      rstn = 1'b1;
      wdata_valid = 1'b1; wdata = 8'h22;
      repeat (6) @(negedge clk);
      wdata_valid = 1'b0;
      wait_idle();
   endtask

   task automatic test_back_to_back();
      send_cmd(1'b1, 4'd8, 4'd2);
      for (int i = 0; i < 3; i++) send_wdata(DW'(8'h40 + i), AW'(8 + i), 3);
      wait_idle();
      for (int i = 0; i < 3; i++) exp_rsp.push_back('{d: DW'(8'h40 + i), last: (i == 2), err: 1'b0});
      send_cmd(1'b0, 4'd8, 4'd2);
      for (int i = 0; i < 3; i++) recv_rsp(0);
      wait_idle();
      vectors++;
      if (b2b_viol !== 0) begin
         miscompares++;
         $display("FAIL ram_en_back_to_back got %0d exp 0", b2b_viol);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap_burst();
      test_timeout();
      test_stall();
      test_reset_mid_burst();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout sim time exceeded");
      $fatal(1);
   end

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, RAM address width (depth 2**ADDR_WIDTH).
REQ-003 SHALL have parameter TIMEOUT, default 7, maximum cycles waited for ram_out_en per read beat.
REQ-004 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports req_valid/req_ready  in/out  1  command handshake.
REQ-007 SHALL have ports req_wr  in  1 (1=write burst, 0=read burst); req_addr  in  ADDR_WIDTH  start address; req_len  in  4  beats minus one.
REQ-008 SHALL have ports wdata_valid/wdata_ready  in/out  1, and wdata  in  DATA_WIDTH  write-beat stream.
REQ-009 SHALL have ports rsp_valid  out  1, rsp_ready  in  1, rsp_data  out  DATA_WIDTH, rsp_last  out  1, rsp_err  out  1  read-beat stream.
REQ-010 SHALL have ports ram_en  out  1, ram_wr_rd  out  1 (1=write), ram_addr  out  ADDR_WIDTH, ram_data_in  out  DATA_WIDTH  RAM command side.
REQ-011 SHALL have ports ram_data_out  in  DATA_WIDTH, ram_out_en  in  1  RAM read-return side.
REQ-012 SHALL have port busy  out  1, high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WR_WAIT, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_RESP; all outputs registered.
REQ-014 IDLE: req_ready=1; on req_valid&&req_ready latch addr, len, wr; go WR_WAIT if wr else RD_ISSUE.
REQ-015 WR_WAIT: wdata_ready=1; on wdata_valid capture wdata into ram_data_in, go WR_ISSUE.
REQ-016 WR_ISSUE: ram_en=1, ram_wr_rd=1 for exactly one cycle; then next beat (WR_WAIT) or IDLE after last beat.
REQ-017 RD_ISSUE: ram_en=1, ram_wr_rd=0 for exactly one cycle, timeout counter cleared; go RD_WAIT.
REQ-018 RD_WAIT: ram_en=0; on ram_out_en capture ram_data_out into rsp_data, rsp_err=0, go RD_RESP; if counter reaches TIMEOUT without ram_out_en, rsp_data=0, rsp_err=1, go RD_RESP.
REQ-019 RD_RESP: rsp_valid=1, rsp_last=1 on final beat; hold rsp_data/rsp_err stable until rsp_ready; then RD_ISSUE for next beat or IDLE.
REQ-020 Only one RAM access outstanding; ram_en SHALL never assert in two consecutive cycles.
REQ-021 Burst length SHALL be req_len+1 beats (1..16); address increments by 1 per beat, wrapping modulo 2**ADDR_WIDTH.
REQ-022 ram_out_en arriving outside RD_WAIT SHALL be ignored.
REQ-023 A read SHALL observe data from a write issued earlier to the same address (write commits on WR_ISSUE edge).
REQ-024 Read latency SHALL be: RAM command cycle N, ram_out_en sampled N+1, rsp_valid at N+2.
REQ-025 rsp_err SHALL not abort the burst; remaining beats continue.

Reset
REQ-026 rstn low at a clock edge SHALL force IDLE from any state, aborting any burst without completing it.
REQ-027 Reset values: req_ready=0 during reset, 1 first cycle after; wdata_ready=0, rsp_valid=0, rsp_last=0, rsp_err=0, rsp_data=0, ram_en=0, ram_wr_rd=0, ram_addr=0, ram_data_in=0, busy=0; beat and timeout counters 0.

Structure
REQ-028 FSM state encoding and width constants (length field width 4, timeout counter width) SHALL live in shared package ram_pkg.
REQ-029 Single flat module; no sub-modules required; intended to connect directly to the team's single-port RAM.

Verification
REQ-030 Write 0xA5 to addr 3 (len 0), then read addr 3 -> one ram_en write pulse addr 3 data 0xA5; rsp_data=0xA5, rsp_last=1, rsp_err=0.
REQ-031 Write burst addr 14, len 3, data 1,2,3,4 -> RAM writes at 14,15,0,1; read burst same -> rsp 1,2,3,4, rsp_last on 4th only.
REQ-032 Read with ram_out_en held low -> rsp_valid after TIMEOUT cycles of RD_WAIT with rsp_data=0, rsp_err=1.
REQ-033 Read burst len 2 with rsp_ready low 5 cycles per beat -> rsp_data stable, no new ram_en until handshake.
REQ-034 rstn low mid write burst (after beat 1) -> next cycle IDLE, ram_en=0, busy=0; remaining beats never written.
REQ-035 Write burst with wdata_valid gaps -> ram_en pulses only after each wdata handshake, never back-to-back.
